// File: rtl/ctrl_parser.sv
// ctrl_parser: per-player game controller front end. Each raw GPIO bit is
// synchronized, debounced, remapped to a 7-bit button vector, SOCD-resolved
// (right+left), registered, and edge-detected into press/release pulses.
// Optional long-press output o_hold is built only when PARSER_HOLD_EN is defined.
module ctrl_parser #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SOCD_NEUTRAL    = 1,
    parameter int HOLD_CYCLES     = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [8*NUM_PLAYERS-1:0] i_data,
    output logic [7*NUM_PLAYERS-1:0] o_btn,
    output logic [7*NUM_PLAYERS-1:0] o_press,
    output logic [7*NUM_PLAYERS-1:0] o_release
`ifdef PARSER_HOLD_EN
    ,
    output logic [7*NUM_PLAYERS-1:0] o_hold
`endif
);

    localparam int NI = 8 * NUM_PLAYERS;
    localparam int NB = 7 * NUM_PLAYERS;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Last count value before the flip; the counter never stores DEBOUNCE_CYCLES itself.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NI-1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NB-1:0]          sync_btn;
    logic [NUM_PLAYERS-1:0] unused_lsb;
    logic [NB-1:0]          stable_q, stable_d;
    logic [CW-1:0]          cnt_q [NB];
    logic [CW-1:0]          cnt_d [NB];
    logic [NB-1:0]          btn_q, btn_d;
    logic [NB-1:0]          press_q, press_d;
    logic [NB-1:0]          release_q, release_d;

    // Two-flop synchronizer next state.
    always_comb begin
        sync1_d = i_data;
        sync2_d = sync1_q;
    end

    // Remap synchronized bits: input bit 8p+1+b feeds button 7p+b; bit 8p is dropped.
    always_comb begin
        sync_btn   = '0;
        unused_lsb = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            unused_lsb[p] = sync2_q[8*p];
            for (int b = 0; b < 7; b++) begin
                sync_btn[7*p+b] = sync2_q[8*p+b+1];
            end
        end
    end

    // Debounce: count consecutive disagreeing cycles, flip stable level on the last one.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync_btn[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // SOCD resolution on stable levels, then edge detection against the registered output.
    always_comb begin
        btn_d = stable_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (SOCD_NEUTRAL != 0 && stable_q[7*p+6] && stable_q[7*p+5]) begin
                btn_d[7*p+6] = 1'b0;
                btn_d[7*p+5] = 1'b0;
            end
        end
        press_d   = btn_d & ~btn_q;
        release_d = ~btn_d & btn_q;
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign o_btn     = btn_q;
    assign o_press   = press_q;
    assign o_release = release_q;

`ifdef PARSER_HOLD_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    logic [HW-1:0] hold_cnt_q [NB];
    logic [HW-1:0] hold_cnt_d [NB];

    // Saturating count of cycles each o_btn bit has been high; o_hold drops with o_btn.
    always_comb begin
        o_hold = '0;
        for (int i = 0; i < NB; i++) begin
            hold_cnt_d[i] = '0;
            if (btn_q[i]) begin
                hold_cnt_d[i] = (hold_cnt_q[i] == HOLD_MAX) ? HOLD_MAX : hold_cnt_q[i] + 1'b1;
            end
            o_hold[i] = btn_q[i] && (hold_cnt_q[i] == HOLD_MAX);
        end
    end

    // Hold counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NB; i++) begin
                hold_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end
`else
    // HOLD_CYCLES has no effect without the hold feature.
    logic unused_hold_cfg;
    assign unused_hold_cfg = (HOLD_CYCLES == 0);
`endif

endmodule

// File: tb/tb_ctrl_parser.sv
// tb_ctrl_parser: directed + random stimulus for ctrl_parser (2 players,
// debounce 4, hold 10, SOCD neutral), checked every cycle against a
// window-based reference model. Define PARSER_HOLD_EN to also check o_hold.
module tb_ctrl_parser;

    localparam int NP = 2;
    localparam int D  = 4;
    localparam int H  = 10;
    localparam int NB = 7 * NP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   i_data;
    logic [NB-1:0] o_btn, o_press, o_release;
`ifdef PARSER_HOLD_EN
    logic [NB-1:0] o_hold;
`endif

    ctrl_parser #(
        .NUM_PLAYERS    (NP),
        .DEBOUNCE_CYCLES(D),
        .SOCD_NEUTRAL   (1),
        .HOLD_CYCLES    (H)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_data   (i_data),
        .o_btn    (o_btn),
        .o_press  (o_press),
        .o_release(o_release)
`ifdef PARSER_HOLD_EN
        ,
        .o_hold   (o_hold)
`endif
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            edge_cnt = 0;
    logic [NB-1:0] st_m, btn_m, press_m, rel_m;
    int            rise_at [NB];
    logic [15:0]   hist [$];

    // Compare one observed vector with its expected value.
    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_cnt, obs, exp);
        end
    endtask

    // Which input bit drives button i.
    function automatic int in_bit(input int i);
        return 8 * (i / 7) + (i % 7) + 1;
    endfunction

    // Right+left both stable -> neither is reported.
    function automatic logic [NB-1:0] socd(input logic [NB-1:0] s);
        logic [NB-1:0] r;
        r = s;
        for (int p = 0; p < NP; p++) begin
            if (s[7*p+6] && s[7*p+5]) begin
                r[7*p+6] = 1'b0;
                r[7*p+5] = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        st_m    = '0;
        btn_m   = '0;
        press_m = '0;
        rel_m   = '0;
        hist.delete();
        repeat (D + 2) hist.push_back(16'h0);
        for (int i = 0; i < NB; i++) rise_at[i] = 0;
    endtask

    task automatic check_all();
        logic [NB-1:0] hold_m;
        hold_m = '0;
        for (int i = 0; i < NB; i++) begin
            hold_m[i] = btn_m[i] && (edge_cnt - rise_at[i] >= H);
        end
        chk("btn", o_btn, btn_m);
        chk("press", o_press, press_m);
        chk("release", o_release, rel_m);
`ifdef PARSER_HOLD_EN
        chk("hold", o_hold, hold_m);
`endif
    endtask

    // One clock edge: advance the model, then compare #1 later.
    task automatic tick();
        logic [NB-1:0] new_btn;
        logic          all_diff;
        int            sz;
        @(posedge clk);
        edge_cnt++;
        if (!rst_n) begin
            model_reset();
        end else begin
            new_btn = socd(st_m);
            sz = hist.size();
            // Level flips once the last D synchronized samples (sampled 2..D+1 edges ago) all disagree.
            for (int i = 0; i < NB; i++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++) begin
                    if (hist[sz-1-j][in_bit(i)] == st_m[i]) all_diff = 1'b0;
                end
                if (all_diff) st_m[i] = ~st_m[i];
            end
            hist.push_back(i_data);
            void'(hist.pop_front());
            press_m = new_btn & ~btn_m;
            rel_m   = ~new_btn & btn_m;
            for (int i = 0; i < NB; i++) begin
                if (press_m[i]) rise_at[i] = edge_cnt;
            end
            btn_m = new_btn;
        end
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Assert reset between edges, check asynchronous clear, hold for n edges.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_btn", o_btn, '0);
        chk("rst_async_press", o_press, '0);
        chk("rst_async_release", o_release, '0);
        run(n);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        int          dur;
        rst_n  = 1'b1;
        i_data = 16'h0;
        model_reset();
        #2;
        do_reset(3);
        run(8);

        // Single jump press on P0: input bit 5 -> button bit 4, visible at edge 6.
        i_data = 16'h0020;
        run(6);
        chk("jump_edge5_btn", o_btn, '0);
        tick();
        chk("jump_edge6_btn", o_btn, 14'h0010);
        chk("jump_edge6_press", o_press, 14'h0010);
        tick();
        chk("jump_edge7_press", o_press, '0);

        // Three-cycle glitch on input bit 13 must not disturb anything.
        i_data = 16'h2020;
        run(3);
        i_data = 16'h0020;
        run(10);
        chk("glitch_btn", o_btn, 14'h0010);

        // SOCD on P0: right held, left pressed then released.
        i_data = 16'h0080;
        run(12);
        chk("right_btn", o_btn, 14'h0040);
        i_data = 16'h00C0;
        run(6);
        chk("left_edge5_btn", o_btn, 14'h0040);
        tick();
        chk("left_edge6_btn", o_btn, '0);
        chk("left_edge6_release", o_release, 14'h0040);
        run(4);
        i_data = 16'h0080;
        run(6);
        tick();
        chk("leftrel_edge6_btn", o_btn, 14'h0040);
        chk("leftrel_edge6_press", o_press, 14'h0040);
        run(3);

        // All buttons held across reset; SOCD neutral on both players.
        i_data = 16'hFFFF;
        do_reset(5);
        run(6);
        chk("allon_edge5_btn", o_btn, '0);
        tick();
        chk("allon_edge6_btn", o_btn, 14'h0F9F);
        chk("allon_edge6_press", o_press, 14'h0F9F);
        run(2);

        // Random stimulus, with a reset dropped in mid-stream.
        for (int s = 0; s < 60; s++) begin
            if (s % 3 == 0) v = 16'($urandom);
            else v = i_data ^ (16'h1 << $urandom_range(0, 15));
            i_data = v;
            dur = $urandom_range(1, 8);
            run(dur);
            if (s == 30) do_reset(2);
        end

        i_data = 16'h0;
        run(12);
`ifdef PARSER_HOLD_EN
        // Long press on P0 select: o_hold follows o_btn by H cycles.
        i_data = 16'h0002;
        run(7);
        chk("sel_btn", o_btn, 14'h0001);
        run(9);
        chk("hold_edge15", 14'(o_hold[0]), 14'h0);
        tick();
        chk("hold_edge16", 14'(o_hold[0]), 14'h1);
        i_data = 16'h0;
        run(7);
        chk("hold_fall", 14'(o_hold[0]), 14'h0);
`endif
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
